// File: rtl/sobel_grad_stream.sv
// Streaming horizontal-gradient edge detector: RGB -> luma -> |dY| -> mask or grey magnitude.
module sobel_grad_stream #(
    parameter int unsigned         CH_W     = 8,
    parameter logic [3*CH_W-1:0]   EDGE_VAL = '1,
    parameter logic [3*CH_W-1:0]   BG_VAL   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sol,
    input  logic [3*CH_W-1:0]   pix_in,
    input  logic [CH_W-1:0]     thresh,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sol,
    output logic [3*CH_W-1:0]   pix_out
);

    localparam int unsigned PIX_W = 3 * CH_W;
    localparam int unsigned SUM_W = CH_W + 2;

    logic                s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]     s1_y_q;
    logic                s1_sol_q;
    logic [CH_W-1:0]     s1_thr_q;
    logic                s1_mode_q;

    logic                s2_valid_q, s2_valid_d;
    logic [PIX_W-1:0]    s2_pix_q;
    logic                s2_sol_q;

    logic [CH_W-1:0]     y_prev_q;
    logic                line_act_q;

    logic                accept;
    logic                s2_adv;
    logic [SUM_W-1:0]    luma_sum;
    logic [CH_W-1:0]     luma_y;
    logic signed [CH_W:0] diff;
    logic signed [CH_W:0] mag;
    logic [CH_W-1:0]     grad;
    logic [PIX_W-1:0]    pix_fmt;

    // Handshake: the pipeline can take a pixel if any stage is empty or the output drains now
    always_comb begin
        in_ready = !s1_valid_q || !s2_valid_q || out_ready;
        accept   = in_valid && in_ready;
        s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    end

    // Luma Y = (R + 2G + B) >> 2, sum is wide enough that no saturation is needed
    always_comb begin
        luma_sum = SUM_W'(pix_in[PIX_W-1 -: CH_W])
                 + (SUM_W'(pix_in[2*CH_W-1 -: CH_W]) << 1)
                 + SUM_W'(pix_in[CH_W-1:0]);
        luma_y   = CH_W'(luma_sum >> 2);
    end

    // Gradient with a signed subtract so a falling step does not wrap; formatted per mode
    always_comb begin
        diff = $signed({1'b0, s1_y_q}) - $signed({1'b0, y_prev_q});
        mag  = diff[CH_W] ? -diff : diff;
        grad = (s1_sol_q || !line_act_q) ? '0 : CH_W'(mag);
        if (s1_mode_q) begin
            pix_fmt = {grad, grad, grad};
        end else begin
            pix_fmt = (grad >= s1_thr_q) ? EDGE_VAL : BG_VAL;
        end
    end

    // Next-state valid bits for both stages
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Stage 1: capture luma and per-pixel controls on input transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s1_sol_q   <= 1'b0;
            s1_thr_q   <= '0;
            s1_mode_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_y_q    <= luma_y;
                s1_sol_q  <= in_sol;
                s1_thr_q  <= thresh;
                s1_mode_q <= mode;
            end
        end
    end

    // Stage 2: output register plus gradient history, updated when stage 1 advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_pix_q   <= '0;
            s2_sol_q   <= 1'b0;
            y_prev_q   <= '0;
            line_act_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_adv) begin
                s2_pix_q   <= pix_fmt;
                s2_sol_q   <= s1_sol_q;
                y_prev_q   <= s1_y_q;
                line_act_q <= 1'b1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sol   = s2_sol_q;
    assign pix_out   = s2_pix_q;

endmodule

// File: doc/sobel_grad_stream.md
Name: sobel_grad_stream

Overview:
- Streaming horizontal-gradient edge detector for 24-bit RGB pixels in the video path.
- Each pixel is reduced to a luma value. The block takes the absolute difference from the previous pixel on the same line and emits either a binary edge mask or a gradient-magnitude grey pixel.
- It replaces the toggle-sampled, unsigned-wrap comparator with a proper valid/ready stream, a 2-stage pipeline, a runtime threshold, line-start handling and an output-mode select.

Parameters:
- CH_W, 8: bits per colour channel; a pixel is 3*CH_W bits, ordered {R,G,B} MSB first.
- EDGE_VAL, all-ones (3*CH_W bits): pixel value emitted for an edge in binary mode.
- BG_VAL, 0 (3*CH_W bits): pixel value emitted for a non-edge in binary mode.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel this cycle.
- in_sol  in  1  start-of-line flag, qualified by in_valid.
- pix_in  in  3*CH_W  RGB input pixel.
- thresh  in  CH_W  edge threshold; sampled with each accepted pixel.
- mode  in  1  0 = binary mask, 1 = magnitude; sampled with each accepted pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_sol  out  1  start-of-line flag aligned with pix_out.
- pix_out  out  3*CH_W  result pixel.

Behaviour:
- Reset (rst low, asynchronous):
  - all pipeline valids, out_valid, out_sol and pix_out clear to 0;
  - the previous-luma register clears to 0;
  - the line-active flag clears to 0.
  - in_ready is 1 while reset is deasserted and the pipeline is empty.
- Handshakes:
  - Input transfer: in_valid && in_ready on a rising edge.
  - Output transfer: out_valid && out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready (a bubble, or a drain this cycle, lets the pipeline advance).
  - pix_out, out_sol and out_valid hold stable while out_valid && !out_ready. No combinational path from in_valid to out_valid.
- Stage 1, luma, registered on input transfer:
  - Y = (R + 2G + B) >> 2.
  - Computed at CH_W+2 bits; the result fits in CH_W bits with no saturation needed.
  - Stage 1 latches Y, sol, thresh and mode.
- Stage 2, gradient, registered when stage 1 advances:
  - If sol, or the line-active flag is 0: D = 0.
  - Otherwise: D = |Y - Y_prev|, computed with a CH_W+1 bit signed subtract, so there is no unsigned wrap.
  - Y_prev <= Y and line-active <= 1 on every stage-2 advance.
- Output formatting:
  - mode 0: pix_out = (D >= thresh) ? EDGE_VAL : BG_VAL.
  - mode 1: pix_out = {D,D,D}.
  - out_sol = stage-1 sol.
- Latency and throughput: 2 accepted-to-valid cycles with out_ready held high; 1 pixel/clock sustained.
- Backpressure: when out_ready is low and both stages are full, in_ready drops in the same cycle. No pixel is dropped or duplicated; ordering is preserved.
- Threshold edge cases:
  - thresh = 0 in mode 0 marks every pixel as an edge, including the first pixel of each line.
  - D equal to thresh counts as an edge.
- Line start:
  - in_sol on any accepted pixel restarts the gradient (D = 0) regardless of history.
  - The first pixel after reset is treated as a line start even without in_sol.
- Simultaneous events: out-transfer and in-transfer in the same cycle with a full pipeline must shift without a bubble.
- Reset mid-stream: all in-flight pixels are discarded. The next accepted pixel is treated as a line start.

Test Plan:
- Flat line: 8 pixels of 0x404040, sol on the first, mode 0, thresh 8, out_ready=1 -> 8 outputs of 0x000000; first out_valid 2 cycles after the first accept; out_sol on output 0 only.
- Step edge: Y sequence 10,10,30,30 (grey pixels), thresh 16, mode 0 -> 0x000000, 0x000000, 0xFFFFFF, 0x000000.
- Downward step (wrap check): Y 200 then 100, mode 1 -> second output 0x646464, not a wrapped value; mode 0 with thresh 0x70 -> 0x000000.
- Boundary and sol: D exactly equal to thresh (Y 50 -> 58, thresh 8) -> 0xFFFFFF. New sol between Y 0 and Y 255 -> D=0, output 0x000000.
- Backpressure: random out_ready (~50%) over 1000 random pixels -> output stream matches the reference model exactly; pix_out is stable while stalled; in_ready is low only when both stages are full and out_ready=0.
- Async reset: assert rst low mid-stream with no clock edge -> out_valid is 0 immediately; after release, the first pixel Y=90 gives D=0 even though the previous pixel was Y=10 with no sol.
